// File: rtl/nibble_mux_arbiter_if.sv
// rtl/nibble_mux_arbiter_if.sv - request/nibble bus shared by the two requesters and the arbiter
interface nibble_mux_arbiter_if;
    logic       req0;
    logic       req1;
    logic [3:0] I0;
    logic [3:0] I1;
    logic       S;
    logic       grant0;
    logic       grant1;
    logic [3:0] O;
    logic       O_valid;
    logic       ack0;
    logic       ack1;

    modport master (
        output req0, req1, I0, I1,
        input  S, grant0, grant1, O, O_valid, ack0, ack1
    );

    modport slave (
        input  req0, req1, I0, I1,
        output S, grant0, grant1, O, O_valid, ack0, ack1
    );
endinterface

// File: rtl/nibble_mux_arbiter.sv
// rtl/nibble_mux_arbiter.sv - round-robin arbiter for the shared 2:1 nibble mux
// Each grant is held HOLD_CYCLES cycles; O is captured once at grant time and frozen.
module nibble_mux_arbiter #(
    parameter int HOLD_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_mux_arbiter_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** HOLD_W) - 1) begin : g_bad_hold
            $error("nibble_mux_arbiter: HOLD_CYCLES out of range 1..2^HOLD_W-1");
        end
    endgenerate

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [3:0]        o_q, o_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              last_q, last_d;

    logic              req_cur;
    logic              take;
    logic [1:0]        win;

    // Returns {pick_valid, pick}; on a tie the requester not served last wins.
    function automatic logic [1:0] arbitrate(input logic e0, input logic e1, input logic last);
        return {e0 | e1, (e0 & e1) ? ~last : e1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            o_q     <= 4'h0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        o_d     = o_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        take    = 1'b0;
        win     = 2'b00;
        req_cur = sel_q ? bus.req1 : bus.req0;

        unique case (state_q)
            IDLE: begin
                win  = arbitrate(bus.req0, bus.req1, last_q);
                take = win[1];
            end
            SERVE: begin
                if (!req_cur) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // End of service: the served requester is masked out of re-arbitration.
                    win  = arbitrate(bus.req0 & sel_q, bus.req1 & ~sel_q, last_q);
                    take = win[1];
                    if (!win[1]) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = SERVE;
            sel_d   = win[0];
            o_d     = win[0] ? bus.I1 : bus.I0;
            cnt_d   = RELOAD;
            last_d  = win[0];
        end
    end

    always_comb begin
        bus.S       = sel_q;
        bus.O       = o_q;
        bus.O_valid = (state_q == SERVE);
        bus.grant0  = (state_q == SERVE) & ~sel_q;
        bus.grant1  = (state_q == SERVE) &  sel_q;
        bus.ack0    = (state_q == SERVE) & ~sel_q & (cnt_q == '0) & bus.req0;
        bus.ack1    = (state_q == SERVE) &  sel_q & (cnt_q == '0) & bus.req1;
    end

endmodule

// File: tb/tb_nibble_mux_arbiter.sv
// tb/tb_nibble_mux_arbiter.sv - scoreboard bench for nibble_mux_arbiter
module tb_nibble_mux_arbiter;

    localparam int HOLD = 4;

    typedef struct packed {
        logic       s;
        logic       g0;
        logic       g1;
        logic [3:0] o;
        logic       ov;
        logic       a0;
        logic       a1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_mux_arbiter_if bus();

    nibble_mux_arbiter #(.HOLD_W(8), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    // Reference: owner (-1 idle), cycles already spent in this service, last served index
    int         owner;
    int         served;
    int         last_srv;
    logic       m_s;
    logic [3:0] m_o;
    logic       x_ack0, x_ack1;

    function automatic logic reqp(input int p);
        return (p == 1) ? bus.req1 : bus.req0;
    endfunction

    task automatic model_reset();
        owner    = -1;
        served   = 0;
        last_srv = 1;
        m_s      = 1'b0;
        m_o      = 4'h0;
    endtask

    task automatic start(input int p);
        owner    = p;
        served   = 1;
        m_s      = (p == 1);
        m_o      = (p == 1) ? bus.I1 : bus.I0;
        last_srv = p;
    endtask

    task automatic model_edge();
        int other;
        if (!rst_n) begin
            model_reset();
        end else if (owner < 0) begin
            if (bus.req0 && bus.req1) start(1 - last_srv);
            else if (bus.req0)        start(0);
            else if (bus.req1)        start(1);
        end else if (!reqp(owner)) begin
            owner = -1;
        end else if (served == HOLD) begin
            other = 1 - owner;
            if (reqp(other)) start(other);
            else             owner = -1;
        end else begin
            served++;
        end
    endtask

    task automatic step();
        exp_t e;
        x_ack0 = (owner == 0) && (served == HOLD) && bus.req0;
        x_ack1 = (owner == 1) && (served == HOLD) && bus.req1;
        e.s  = m_s;
        e.g0 = (owner == 0);
        e.g1 = (owner == 1);
        e.o  = m_o;
        e.ov = (owner >= 0);
        e.a0 = x_ack0;
        e.a1 = x_ack1;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n, input bit drop0, input bit drop1);
        for (int i = 0; i < n; i++) begin
            step();
            if (drop0 && x_ack0) bus.req0 = 1'b0;
            if (drop1 && x_ack1) bus.req1 = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cycle_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{bus.S, bus.grant0, bus.grant1, bus.O, bus.O_valid, bus.ack0, bus.ack1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got S=%b g=%b%b O=%h v=%b ack=%b%b, expected S=%b g=%b%b O=%h v=%b ack=%b%b",
                         cycle_no, a.s, a.g0, a.g1, a.o, a.ov, a.a0, a.a1,
                         e.s, e.g0, e.g1, e.o, e.ov, e.a0, e.a1);
            end
        end
    end

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.I0   = 4'h0;
        bus.I1   = 4'h0;
        model_reset();
        @(posedge clk);
        #1;
        run(2, 0, 0);
        rst_n = 1'b1;

        // simultaneous first requests: 0 wins, then 1 with no gap
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.I0 = 4'h3; bus.I1 = 4'hC;
        run(12, 1, 1);

        // single request
        bus.req0 = 1'b1; bus.I0 = 4'hA;
        run(8, 1, 0);

        // persistent contention: strict alternation
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        run(24, 0, 0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        run(2, 0, 0);

        // input change during service is ignored
        bus.req0 = 1'b1; bus.I0 = 4'h5;
        run(2, 1, 0);
        bus.I0 = 4'hF;
        run(6, 1, 0);

        // abort in the second SERVE cycle
        bus.req1 = 1'b1; bus.I1 = 4'h7;
        run(2, 0, 0);
        bus.req1 = 1'b0;
        run(3, 0, 0);

        // asynchronous reset in the third SERVE cycle, then both request
        bus.req0 = 1'b1; bus.I0 = 4'h9;
        run(3, 0, 0);
        rst_n = 1'b0;
        model_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.I1 = 4'h2;
        run(2, 0, 0);
        rst_n = 1'b1;
        run(10, 1, 1);

        // randomized traffic, including occasional aborts
        for (int i = 0; i < 600; i++) begin
            if (bus.req0) begin
                if ((x_ack0 && $urandom_range(0, 1) == 0) || $urandom_range(0, 19) == 0) bus.req0 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1;
            end
            if (bus.req1) begin
                if ((x_ack1 && $urandom_range(0, 1) == 0) || $urandom_range(0, 19) == 0) bus.req1 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1;
            end
            bus.I0 = 4'($urandom_range(0, 15));
            bus.I1 = 4'($urandom_range(0, 15));
            step();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_mux_arbiter.md
Name: nibble_mux_arbiter

Overview:
- Round-robin arbiter that shares the 4-bit 2:1 nibble mux between two requesters.
- Drives the mux select `S` and registers the selected nibble for the downstream HEX decoder.
- Holds each grant for a programmable minimum number of cycles so the displayed value stays stable.
- Signals completion to the served requester with a one-cycle ack pulse.

Parameters:
- HOLD_W, 8: width of the hold counter.
- HOLD_CYCLES, 4: cycles each grant is held. Legal range 1 to 2^HOLD_W-1. 0 is illegal; the implementation asserts on it in simulation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req0  input  1  request from requester 0; hold high until ack0.
- req1  input  1  request from requester 1; hold high until ack1.
- I0  input  4  nibble from requester 0.
- I1  input  4  nibble from requester 1.
- S  output  1  mux select (0=I0, 1=I1), registered.
- grant0  output  1  requester 0 owns the mux.
- grant1  output  1  requester 1 owns the mux.
- O  output  4  registered selected nibble.
- O_valid  output  1  O holds a currently granted value.
- ack0  output  1  one-cycle pulse, last cycle of requester 0 service.
- ack1  output  1  one-cycle pulse, last cycle of requester 1 service.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; S=0; O=4'h0; O_valid=0; grant0=grant1=0; ack0=ack1=0; counter=0.
  - last_served pointer=1, so requester 0 wins the first tie.
- States: IDLE, SERVE.
- Arbitration function, given an eligible request set:
  - Only one requester eligible: pick it.
  - Both eligible: pick the one not equal to last_served.
  - None eligible: no pick.
- IDLE:
  - grants=0, O_valid=0, acks=0; S and O hold their last values.
  - At a clock edge with req0|req1 sampled high, arbitrate over {req0, req1}.
  - On a pick p, the next cycle is SERVE:
    - S=p, grant_p=1, O_valid=1.
    - O captures I_p as sampled at that edge.
    - counter loads HOLD_CYCLES-1; last_served<=p.
  - Latency: req sampled at edge k gives grant/O_valid high after edge k.
- SERVE:
  - O is frozen for the whole service; changes on I_p after capture are ignored.
  - Counter decrements by one per cycle while nonzero.
  - ack_p is asserted combinationally in the SERVE cycle where counter==0 and req_p==1.
  - Service therefore lasts exactly HOLD_CYCLES cycles. With HOLD_CYCLES=1, ack is in the first SERVE cycle.
- End of service (edge of the ack cycle):
  - Re-arbitrate with the served requester masked out.
  - Other requester's req high: switch directly to SERVE for it (capture, reload counter, flip S, update last_served), with no IDLE gap.
  - Otherwise: go to IDLE.
- Abort:
  - If req_p is sampled low during SERVE before the ack cycle, the next cycle is IDLE.
  - No ack is issued; O_valid drops; O and S hold.
  - last_served stays p.
- Re-request: a requester that keeps req high after its ack is served again only after the other requester is served or the arbiter returns to IDLE. This gives strict alternation under contention.
- Invariants:
  - Never both grants high.
  - Never both acks high.
  - ack_p implies grant_p.
  - O_valid == grant0|grant1.
  - S always equals the granted index while O_valid=1.

Test Plan (HOLD_CYCLES=4):
1. Single request:
   - Stimulus: req0=1, I0=4'hA, req1=0; drop req0 the cycle after ack0.
   - Response: next cycle grant0=1, S=0, O=A, O_valid=1 for 4 cycles; ack0 in the 4th; then IDLE with O=A held and O_valid=0.
2. Simultaneous first requests:
   - Stimulus: from reset, req0=req1=1, I0=4'h3, I1=4'hC; each req dropped after its ack.
   - Response: grant0 for 4 cycles with O=3, S=0, ack0 on cycle 4; then immediately grant1 for 4 cycles with O=C, S=1, ack1 on cycle 8; then IDLE.
3. Persistent requests:
   - Stimulus: req0 and req1 held high for 24 cycles.
   - Response: service order 0,1,0,1,0,1, each exactly 4 cycles; acks every 4th cycle; no IDLE cycles.
4. Input change during service:
   - Stimulus: while granted with O=5, change I0 to 4'hF.
   - Response: O stays 5 until the next capture.
5. Abort:
   - Stimulus: req1 alone, I1=4'h7; drop req1 in the 2nd SERVE cycle.
   - Response: no ack1 ever; next cycle IDLE with grant1=0, O_valid=0, O=7, S=1.
6. Reset mid-service:
   - Stimulus: pull rst_n low in the 3rd SERVE cycle with O=9.
   - Response: immediately (without a clock edge) S=0, O=0, O_valid=0, grants=0, acks=0. After release with both reqs high, requester 0 is served first.
